// File: rtl/bitwise_accum_unit.sv
`default_nettype none
// ============================================================================
//  Module      : bitwise_accum_unit
//  Description : Selectable bitwise op (8 choices) on operands a/b, optionally
//                chained over a multi-beat transaction into an accumulator.
//                Valid/ready in, valid/ready out with registered popcount and
//                zero flags alongside the result.
//  Revision    : 1.0 - initial release
// ============================================================================
module bitwise_accum_unit #(
  parameter int WIDTH   = 8,
  parameter int BEATS_W = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           a,
  input  logic [WIDTH-1:0]           b,
  input  logic [2:0]                 op,
  input  logic                       acc_mode,
  input  logic [BEATS_W-1:0]         beats,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           result,
  output logic [$clog2(WIDTH+1)-1:0] popcnt,
  output logic                       zero
);

  localparam int PCNT_W = $clog2(WIDTH+1);

  localparam logic [1:0] C_IDLE  = 2'd0;
  localparam logic [1:0] C_ACCUM = 2'd1;
  localparam logic [1:0] C_DONE  = 2'd2;

  logic [1:0]         r_state;
  logic [2:0]         r_op;
  logic [WIDTH-1:0]   r_acc;
  logic [BEATS_W-1:0] r_remaining;
  logic [WIDTH-1:0]   r_result;
  logic [PCNT_W-1:0]  r_popcnt;
  logic               r_zero;

  logic [2:0]         w_sel;
  logic [WIDTH-1:0]   w_x;
  logic [WIDTH-1:0]   w_next;
  logic [PCNT_W-1:0]  w_pop;
  logic               w_xfer;
  logic               w_finish;

  // Bitwise operation table; op 6 clears the bits of x that are set in y.
  function automatic logic [WIDTH-1:0] apply_op(input logic [2:0]       sel,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] f;
    case (sel)
      3'd0:    f = x & y;
      3'd1:    f = x | y;
      3'd2:    f = x ^ y;
      3'd3:    f = ~(x & y);
      3'd4:    f = ~(x | y);
      3'd5:    f = ~(x ^ y);
      3'd6:    f = x & ~y;
      default: f = x;
    endcase
    return f;
  endfunction

  // Handshake status; an unreachable encoding reports not-ready until it recovers.
  always_comb begin
    in_ready  = (r_state == C_IDLE) || (r_state == C_ACCUM);
    out_valid = (r_state == C_DONE);
    w_xfer    = in_valid && in_ready;
  end

  // Next accumulator value: first beat uses a and the live op, later beats fold into acc.
  always_comb begin
    w_sel  = (r_state == C_IDLE) ? op : r_op;
    w_x    = (r_state == C_IDLE) ? a  : r_acc;
    w_next = apply_op(w_sel, w_x, b);
    w_pop  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_pop = w_pop + {{(PCNT_W-1){1'b0}}, w_next[i]};
    end
  end

  // The beat being accepted is the last one of its transaction.
  always_comb begin
    w_finish = 1'b0;
    if (w_xfer) begin
      if (r_state == C_IDLE) begin
        w_finish = !acc_mode || (beats == '0);
      end else begin
        w_finish = (r_remaining == BEATS_W'(1));
      end
    end
  end

  // Transaction state machine and accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= C_IDLE;
      r_op        <= 3'd0;
      r_acc       <= '0;
      r_remaining <= '0;
    end else begin
      case (r_state)
        C_IDLE: begin
          if (w_xfer) begin
            r_op  <= op;
            r_acc <= w_next;
            if (w_finish) begin
              r_state <= C_DONE;
            end else begin
              r_remaining <= beats;
              r_state     <= C_ACCUM;
            end
          end
        end
        C_ACCUM: begin
          if (w_xfer) begin
            r_acc       <= w_next;
            r_remaining <= r_remaining - BEATS_W'(1);
            if (w_finish) begin
              r_state <= C_DONE;
            end
          end
        end
        C_DONE: begin
          if (out_ready) begin
            r_state <= C_IDLE;
          end
        end
        default: begin
          r_state <= C_IDLE;
        end
      endcase
    end
  end

  // Output register: captured from the final acc value on the edge that enters DONE, held otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= '0;
      r_popcnt <= '0;
      r_zero   <= 1'b0;
    end else if (w_finish) begin
      r_result <= w_next;
      r_popcnt <= w_pop;
      r_zero   <= (w_next == '0);
    end
  end

  assign result = r_result;
  assign popcnt = r_popcnt;
  assign zero   = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_bitwise_accum_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bitwise_accum_unit
//  Description : Scoreboard bench for bitwise_accum_unit (WIDTH=8, BEATS_W=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bitwise_accum_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] op;
  logic       acc_mode;
  logic [3:0] beats;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic [3:0] popcnt;
  logic       zero;

  logic fixed_rdy;
  logic rand_rdy;
  logic r_rand_bit;

  typedef struct {
    logic [7:0] res;
    logic [3:0] pc;
    logic       z;
  } exp_t;

  exp_t       sb_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         xfers   = 0;
  logic [7:0] bv [0:15];

  assign out_ready = rand_rdy ? r_rand_bit : fixed_rdy;

  bitwise_accum_unit #(.WIDTH(8), .BEATS_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .acc_mode(acc_mode), .beats(beats),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .popcnt(popcnt), .zero(zero)
  );

  always #5 clk = ~clk;

  // Random consumer backpressure.
  always @(posedge clk) begin
    #1 r_rand_bit = 1'($urandom_range(0, 1));
  end

  // Count accepted beats (sampled mid-cycle, transfer happens on the next edge).
  always @(negedge clk) begin
    if (!rst && in_valid && in_ready) xfers++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference behaviour of one operation.
  function automatic logic [7:0] ref_op(input int o, input logic [7:0] x, input logic [7:0] y);
    case (o)
      0: return x & y;
      1: return x | y;
      2: return x ^ y;
      3: return ~(x & y);
      4: return ~(x | y);
      5: return ~(x ^ y);
      6: return x & ~y;
      default: return x;
    endcase
  endfunction

  // Monitor: every cycle the output is presented it must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_output: got %0h expected none", result);
      end else begin
        check("mon_result", result, sb_q[0].res);
        check("mon_popcnt", popcnt, sb_q[0].pc);
        check("mon_zero",   zero,   sb_q[0].z);
        if (out_ready) void'(sb_q.pop_front());
      end
    end
  end

  // Issue one transaction using bv[] as the b sequence; abort_after>=0 resets before that beat.
  task automatic send(input logic [2:0] o, input logic [7:0] av, input logic am,
                      input logic [3:0] nb, input int gap_max, input int abort_after);
    int         nbeats;
    logic [7:0] acc;
    exp_t       e;
    nbeats = am ? int'(nb) + 1 : 1;
    acc = ref_op(int'(o), av, bv[0]);
    for (int i = 1; i < nbeats; i++) acc = ref_op(int'(o), acc, bv[i]);
    for (int i = 0; i < nbeats; i++) begin
      int cnt;
      if (i == abort_after) begin
        rst = 1'b1;
        @(posedge clk) #1;
        rst = 1'b0;
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_in_ready",  in_ready,  1'b1);
        return;
      end
      repeat ($urandom_range(0, gap_max)) @(posedge clk) #1;
      in_valid = 1'b1;
      b        = bv[i];
      a        = (i == 0) ? av : 8'($urandom);
      op       = (i == 0) ? o  : 3'($urandom);
      acc_mode = (i == 0) ? am : 1'($urandom);
      beats    = (i == 0) ? nb : 4'($urandom);
      if (i == nbeats - 1) begin
        e.res = acc;
        e.pc  = 4'($countones(acc));
        e.z   = (acc == 8'h00);
        sb_q.push_back(e);
      end
      cnt = 0;
      while (!in_ready && cnt < 200) begin
        @(posedge clk) #1;
        cnt++;
      end
      if (!in_ready) begin
        check("in_ready_timeout", in_ready, 1'b1);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk) #1;
      in_valid = 1'b0;
    end
    check("done_latency", out_valid, 1'b1);
  endtask

  task automatic drain();
    int cnt = 0;
    while ((sb_q.size() != 0 || out_valid) && cnt < 300) begin
      @(posedge clk) #1;
      cnt++;
    end
    if (sb_q.size() != 0 || out_valid) check("drain_timeout", sb_q.size(), 0);
  endtask

  initial begin
    logic [7:0] sweep [0:7];
    int         x0;
    sweep[0] = 8'h0A; sweep[1] = 8'hCF; sweep[2] = 8'hC5; sweep[3] = 8'hF5;
    sweep[4] = 8'h30; sweep[5] = 8'h3A; sweep[6] = 8'hC0; sweep[7] = 8'hCA;

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = '0; acc_mode = 1'b0; beats = '0;
    fixed_rdy = 1'b1; rand_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_result",    result,    8'h00);
    check("rst_popcnt",    popcnt,    4'd0);
    check("rst_zero",      zero,      1'b0);
    check("rst_in_ready",  in_ready,  1'b1);
    rst = 1'b0;
    @(posedge clk) #1;

    // Single-beat AND.
    bv[0] = 8'h3C;
    send(3'd0, 8'hF0, 1'b0, 4'd0, 0, -1);
    check("t1_result", result, 8'h30);
    check("t1_popcnt", popcnt, 4'd2);
    drain();

    // Op sweep.
    for (int o = 0; o < 8; o++) begin
      bv[0] = 8'h0F;
      send(3'(o), 8'hCA, 1'b0, 4'd0, 0, -1);
      check("t2_sweep", result, sweep[o]);
      drain();
    end

    // Four-beat XOR chain.
    bv[0] = 8'h0F; bv[1] = 8'h33; bv[2] = 8'h55; bv[3] = 8'hFF;
    x0 = xfers;
    send(3'd2, 8'hFF, 1'b1, 4'd3, 0, -1);
    check("t3_result", result, 8'h69);
    check("t3_popcnt", popcnt, 4'd4);
    check("t3_xfers",  xfers - x0, 4);
    drain();

    // Output backpressure with ignored input beats.
    fixed_rdy = 1'b0;
    bv[0] = 8'h3C;
    x0 = xfers;
    send(3'd0, 8'hF0, 1'b0, 4'd0, 0, -1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; a = 8'($urandom); b = 8'($urandom); op = 3'($urandom);
      @(posedge clk) #1;
      check("t4_in_ready", in_ready,  1'b0);
      check("t4_valid",    out_valid, 1'b1);
      check("t4_result",   result,    8'h30);
    end
    in_valid  = 1'b0;
    fixed_rdy = 1'b1;
    @(posedge clk) #1;
    check("t4_released_valid", out_valid, 1'b0);
    check("t4_released_ready", in_ready,  1'b1);
    check("t4_result_kept",    result,    8'h30);
    check("t4_xfers",          xfers - x0, 1);
    repeat (3) @(posedge clk) #1;
    check("t4_no_extra", out_valid, 1'b0);

    // Reset in the middle of a chain, then a zero result.
    for (int i = 0; i < 4; i++) bv[i] = 8'($urandom);
    send(3'($urandom), 8'($urandom), 1'b1, 4'd3, 0, 2);
    repeat (2) @(posedge clk) #1;
    check("t5_no_emit", out_valid, 1'b0);
    bv[0] = 8'h00;
    send(3'd1, 8'h00, 1'b0, 4'd0, 0, -1);
    check("t5_result", result, 8'h00);
    check("t5_zero",   zero,   1'b1);
    check("t5_popcnt", popcnt, 4'd0);
    drain();

    // Sixteen-beat XOR fold with input gaps.
    for (int i = 0; i < 16; i++) bv[i] = 8'($urandom);
    x0 = xfers;
    send(3'd2, 8'($urandom), 1'b1, 4'd15, 2, -1);
    check("t6_xfers", xfers - x0, 16);
    drain();

    // Randomized transactions with random consumer backpressure.
    rand_rdy = 1'b1;
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 16; i++) bv[i] = 8'($urandom);
      send(3'($urandom), 8'($urandom), 1'($urandom), 4'($urandom_range(0, 5)), 2, -1);
    end
    drain();
    rand_rdy = 1'b0;
    repeat (2) @(posedge clk) #1;
    check("final_queue_empty", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
